// File: rtl/module_reg_ctrl_uart_multi_pkg.sv
// Shared definitions for the multi-channel UART control register:
// control-word bit positions and the per-channel launch state type.
// Optional feature macro used by the design: UART_REG_IRQ_EN.
package pkg_uart_reg;

  localparam int BIT_SEND = 0;
  localparam int BIT_DONE = 1;
  localparam int BIT_ERR  = 2;
  localparam int BIT_IE   = 3;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } ch_state_t;

endpackage

// File: rtl/module_reg_ctrl_uart_multi_ch.sv
// One UART control channel: control word register, launch FSM and
// busy timeout counter. With UART_REG_IRQ_EN defined, irq is a registered
// IE & (DONE | ERR); otherwise irq is tied low and IE is plain storage.
module module_reg_ctrl_uart_ch
  import pkg_uart_reg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_micro,
  input  logic [DATA_W/8-1:0] be_micro,
  input  logic [DATA_W-1:0]   data,
  input  logic                we_fsm,
  input  logic [DATA_W-1:0]   fsm_data,
  input  logic                busy,
  output logic [DATA_W-1:0]   word,
  output logic                start,
  output logic                irq
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  ch_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] word_n;
  logic              hw_done, hw_err;

  // State, timeout counter and control word registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      word  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      word  <= word_n;
    end
  end

  // Launch sequencing, status events and word write precedence
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hw_done = 1'b0;
    hw_err  = 1'b0;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (word[BIT_SEND]) state_n = LAUNCH;
      end
      LAUNCH: begin
        start   = !rst_i;
        cnt_n   = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_n = WAIT_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == TIMEOUT_VAL) begin
            hw_err  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          hw_done = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    word_n = word;
    if (we_fsm) begin
      word_n = fsm_data;
    end else begin
      if (we_micro) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be_micro[b]) word_n[b*8 +: 8] = data[b*8 +: 8];
        end
      end
      if (hw_done) begin
        word_n[BIT_DONE] = 1'b1;
        word_n[BIT_SEND] = 1'b0;
      end
      if (hw_err) begin
        word_n[BIT_ERR]  = 1'b1;
        word_n[BIT_SEND] = 1'b0;
      end
    end
  end

`ifdef UART_REG_IRQ_EN
  // Interrupt follows the enabled status bits one cycle later
  always_ff @(posedge clk_i) begin
    if (rst_i) irq <= 1'b0;
    else       irq <= word[BIT_IE] & (word[BIT_DONE] | word[BIT_ERR]);
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: rtl/module_reg_ctrl_uart_multi.sv
// Multi-channel UART control register top: decodes the processor channel
// select and packs the per-channel words. Interrupts exist only when
// UART_REG_IRQ_EN is defined.
module module_reg_ctrl_uart_multi
  import pkg_uart_reg::*;
#(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     we_micro_i,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel_micro_i,
  input  logic [DATA_W/8-1:0]                      be_micro_i,
  input  logic [DATA_W-1:0]                        data_i,
  input  logic [N_CH-1:0]                          we_fsm_i,
  input  logic [N_CH*DATA_W-1:0]                   instruccion_fsm_i,
  input  logic [N_CH-1:0]                          busy_i,
  output logic [N_CH*DATA_W-1:0]                   instrucciones_fsm_o,
  output logic [N_CH-1:0]                          start_o,
  output logic [N_CH-1:0]                          irq_o
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Out-of-range selects match no channel, so those writes are dropped
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic sel_hit;
    assign sel_hit = we_micro_i && (ch_sel_micro_i == SEL_W'(k));

    module_reg_ctrl_uart_ch #(
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .we_micro (sel_hit),
      .be_micro (be_micro_i),
      .data     (data_i),
      .we_fsm   (we_fsm_i[k]),
      .fsm_data (instruccion_fsm_i[k*DATA_W +: DATA_W]),
      .busy     (busy_i[k]),
      .word     (instrucciones_fsm_o[k*DATA_W +: DATA_W]),
      .start    (start_o[k]),
      .irq      (irq_o[k])
    );
  end

endmodule

// File: tb/tb_module_reg_ctrl_uart_multi.sv
// Self-checking bench for module_reg_ctrl_uart_multi: directed scenarios
// followed by random traffic, all compared against a behavioural model.
// Honours UART_REG_IRQ_EN for the expected interrupt behaviour.
module tb_module_reg_ctrl_uart_multi;

  localparam int N_CH    = 3;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int SEL_W   = 2;
`ifdef UART_REG_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b0;
  logic                   we_micro_i = 1'b0;
  logic [SEL_W-1:0]       ch_sel_micro_i = '0;
  logic [3:0]             be_micro_i = '0;
  logic [DATA_W-1:0]      data_i = '0;
  logic [N_CH-1:0]        we_fsm_i = '0;
  logic [N_CH*DATA_W-1:0] instruccion_fsm_i = '0;
  logic [N_CH-1:0]        busy_i = '0;
  logic [N_CH*DATA_W-1:0] instrucciones_fsm_o;
  logic [N_CH-1:0]        start_o;
  logic [N_CH-1:0]        irq_o;

  module_reg_ctrl_uart_multi #(
    .N_CH        (N_CH),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .we_micro_i          (we_micro_i),
    .ch_sel_micro_i      (ch_sel_micro_i),
    .be_micro_i          (be_micro_i),
    .data_i              (data_i),
    .we_fsm_i            (we_fsm_i),
    .instruccion_fsm_i   (instruccion_fsm_i),
    .busy_i              (busy_i),
    .instrucciones_fsm_o (instrucciones_fsm_o),
    .start_o             (start_o),
    .irq_o               (irq_o)
  );

  // 10 ns system clock
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int start_cnt0 = 0;
  bit model_valid = 0;

  // Reference model: each channel has a control word and a notion of
  // where its current transmission stands
  logic [DATA_W-1:0] m_word [N_CH];
  bit                m_launch_now [N_CH];
  bit                m_need_busy  [N_CH];
  bit                m_need_idle  [N_CH];
  int                m_idle_wait  [N_CH];
  logic [N_CH-1:0]   m_irq;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] wordOf(input int k);
    return instrucciones_fsm_o[k*DATA_W +: DATA_W];
  endfunction

  task automatic modelStep(input bit rst, input bit wm, input logic [SEL_W-1:0] sel,
                           input logic [3:0] be, input logic [DATA_W-1:0] d,
                           input logic [N_CH-1:0] wf, input logic [N_CH*DATA_W-1:0] fd,
                           input logic [N_CH-1:0] bz);
    for (int k = 0; k < N_CH; k++) begin
      logic [DATA_W-1:0] w;
      bit done_ev, err_ev, launch_next;
      w = m_word[k];
      done_ev = 0;
      err_ev = 0;
      launch_next = 0;
      if (m_launch_now[k]) begin
        m_need_busy[k] = 1;
        m_idle_wait[k] = 0;
      end else if (m_need_busy[k]) begin
        if (bz[k]) begin
          m_need_busy[k] = 0;
          m_need_idle[k] = 1;
        end else begin
          m_idle_wait[k]++;
          if (m_idle_wait[k] == TIMEOUT) begin
            err_ev = 1;
            m_need_busy[k] = 0;
          end
        end
      end else if (m_need_idle[k]) begin
        if (!bz[k]) begin
          done_ev = 1;
          m_need_idle[k] = 0;
        end
      end else if (m_word[k][0]) begin
        launch_next = 1;
      end
      m_launch_now[k] = launch_next;
      m_irq[k] = IRQ_ON && m_word[k][3] && (m_word[k][1] || m_word[k][2]);
      if (wf[k]) begin
        w = fd[k*DATA_W +: DATA_W];
      end else begin
        if (wm && int'(sel) == k) begin
          for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        if (done_ev) begin w[1] = 1'b1; w[0] = 1'b0; end
        if (err_ev)  begin w[2] = 1'b1; w[0] = 1'b0; end
      end
      m_word[k] = w;
      if (rst) begin
        m_word[k] = '0;
        m_launch_now[k] = 0;
        m_need_busy[k] = 0;
        m_need_idle[k] = 0;
        m_idle_wait[k] = 0;
        m_irq[k] = 1'b0;
      end
    end
    if (rst) model_valid = 1;
  endtask

  // Drives one cycle of inputs, compares outputs with the model, then
  // advances the model across the coming clock edge
  task automatic applyStimulus(input bit rst, input bit wm, input logic [SEL_W-1:0] sel,
                               input logic [3:0] be, input logic [DATA_W-1:0] d,
                               input logic [N_CH-1:0] wf, input logic [N_CH*DATA_W-1:0] fd,
                               input logic [N_CH-1:0] bz);
    logic [N_CH-1:0] exp_start;
    @(negedge clk_i);
    rst_i = rst;
    we_micro_i = wm;
    ch_sel_micro_i = sel;
    be_micro_i = be;
    data_i = d;
    we_fsm_i = wf;
    instruccion_fsm_i = fd;
    busy_i = bz;
    #1;
    if (model_valid) begin
      for (int k = 0; k < N_CH; k++) exp_start[k] = m_launch_now[k] && !rst;
      for (int k = 0; k < N_CH; k++) checkOutput($sformatf("word%0d", k), wordOf(k), m_word[k]);
      checkOutput("start", start_o, exp_start);
      checkOutput("irq", irq_o, m_irq);
    end
    if (start_o[0] === 1'b1) start_cnt0++;
    modelStep(rst, wm, sel, be, d, wf, fd, bz);
  endtask

  task automatic idleCycles(input int n, input logic [N_CH-1:0] bz);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, '0, '0, bz);
  endtask

  task automatic sampleAfterEdge();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [N_CH*DATA_W-1:0] fd;
    logic [N_CH-1:0] bz;
    for (int k = 0; k < N_CH; k++) begin
      m_word[k] = '0;
      m_launch_now[k] = 0;
      m_need_busy[k] = 0;
      m_need_idle[k] = 0;
      m_idle_wait[k] = 0;
    end
    m_irq = '0;

    // Reset held for two cycles
    applyStimulus(1, 0, '0, '0, '0, '0, '0, '0);
    applyStimulus(1, 0, '0, '0, '0, '0, '0, '0);
    sampleAfterEdge();
    checkOutput("rst_words", instrucciones_fsm_o, '0);
    checkOutput("rst_start", start_o, '0);
    checkOutput("rst_irq", irq_o, '0);

    // Byte-enabled write to channel 1
    applyStimulus(0, 1, 2'd1, 4'b0100, 32'hAABBCCD0, '0, '0, '0);
    sampleAfterEdge();
    checkOutput("be_word1", wordOf(1), 32'h00BB0000);
    checkOutput("be_word0", wordOf(0), 32'h0);

    // FSM write beats a processor write on the same channel
    fd = '0;
    fd[31:0] = 32'h12345670;
    applyStimulus(0, 1, 2'd0, 4'hF, 32'hFFFFFFF0, 3'b001, fd, '0);
    sampleAfterEdge();
    checkOutput("collide_word0", wordOf(0), 32'h12345670);

    // Select beyond the last channel is dropped
    applyStimulus(0, 1, 2'd3, 4'hF, 32'hFFFFFFFF, '0, '0, '0);
    sampleAfterEdge();
    checkOutput("oob_word0", wordOf(0), 32'h12345670);
    checkOutput("oob_word1", wordOf(1), 32'h00BB0000);
    checkOutput("oob_word2", wordOf(2), 32'h0);

    // Launch with busy handshake to completion
    start_cnt0 = 0;
    applyStimulus(0, 1, 2'd0, 4'hF, 32'h9, '0, '0, '0);
    idleCycles(2, 3'b000);
    idleCycles(5, 3'b001);
    idleCycles(1, 3'b000);
    sampleAfterEdge();
    checkOutput("done_word0", wordOf(0), 32'hA);
    idleCycles(1, 3'b000);
    sampleAfterEdge();
    checkOutput("done_irq0", irq_o[0], IRQ_ON);
    checkOutput("done_starts", start_cnt0, 1);

    // Busy never arrives: timeout raises ERR
    start_cnt0 = 0;
    applyStimulus(0, 1, 2'd0, 4'hF, 32'h1, '0, '0, '0);
    idleCycles(2 + TIMEOUT, 3'b000);
    sampleAfterEdge();
    checkOutput("timeout_word0", wordOf(0), 32'h4);
    idleCycles(4, 3'b000);
    checkOutput("timeout_starts", start_cnt0, 1);

    // Reset while waiting for busy to drop
    applyStimulus(0, 1, 2'd0, 4'hF, 32'h1, '0, '0, '0);
    idleCycles(2, 3'b000);
    idleCycles(2, 3'b001);
    start_cnt0 = 0;
    applyStimulus(1, 0, '0, '0, '0, '0, '0, 3'b001);
    idleCycles(5, 3'b000);
    sampleAfterEdge();
    checkOutput("midrst_word0", wordOf(0), 32'h0);
    checkOutput("midrst_starts", start_cnt0, 0);

    // Random traffic against the model
    bz = '0;
    for (int i = 0; i < 3000; i++) begin
      logic [DATA_W-1:0] d;
      logic [N_CH-1:0] wf;
      d = $urandom;
      d[0] = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < N_CH; k++) begin
        if ($urandom_range(0, 3) == 0) bz[k] = ~bz[k];
        wf[k] = ($urandom_range(0, 15) == 0);
        fd[k*DATA_W +: DATA_W] = $urandom;
      end
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                    SEL_W'($urandom_range(0, 3)), 4'($urandom), d, wf, fd, bz);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
